// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
// Holds the drain FSM state encoding and the palette index width.
package sprite_pkg;

  localparam int PAL_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker for the sprite ROM arbiter.
// Search starts at ptr+1 and wraps; returns one-hot and index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx,
  output logic             pick_any
);

  logic [IW-1:0] cand;

  // first requester found walking forward from the slot after ptr
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!pick_any && req[cand]) begin
        pick_any   = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM between N_REQ requesters.
// rom_q is captured RD_LAT edges after the rom_addr register loads.
// Define SPRITE_ARB_STATS_EN to add per-requester grant counters.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int AW     = 8,
  parameter int RD_LAT = 2
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [AW-1:0]       rom_addr,
  input  logic [PAL_W-1:0]    rom_q,
  output logic [N_REQ-1:0]    rd_valid,
  output logic [PAL_W-1:0]    rd_data,
  input  logic                freeze,
  output logic                halted
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] grant_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  tag_t             tag_q [RD_LAT];
  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             grant_now;
  logic             in_flight;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // freeze always wins; dropping it lets a grant go out on the same edge
  assign grant_now = pick_any & ~freeze;

  // any read still travelling through the tag pipeline
  always_comb begin
    in_flight = 1'b0;
    for (int k = 0; k < RD_LAT; k++) begin
      in_flight = in_flight | tag_q[k].vld;
    end
  end

  // grant, ROM address and round-robin pointer
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      gnt      <= '0;
      rom_addr <= '0;
      ptr      <= IW'(N_REQ - 1);
    end else begin
      gnt <= grant_now ? pick : '0;
      if (grant_now) begin
        rom_addr <= req_addr[int'(pick_idx)*AW +: AW];
        ptr      <= pick_idx;
      end
    end
  end

  // requester tags riding alongside the ROM latency
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      for (int k = 0; k < RD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: grant_now, idx: pick_idx};
      for (int k = 1; k < RD_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // return strobe and data; data holds when nothing returns
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= '0;
      if (tag_q[RD_LAT-1].vld) begin
        rd_valid <= N_REQ'(1) << tag_q[RD_LAT-1].idx;
        rd_data  <= rom_q;
      end
    end
  end

  // freeze FSM: drain in-flight reads, then report halted
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (freeze) begin
            state  <= in_flight ? DRAIN : HALT;
            halted <= ~in_flight;
          end
        end
        DRAIN: begin
          if (!freeze) begin
            state  <= RUN;
            halted <= 1'b0;
          end else if (!in_flight) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (!freeze) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPRITE_ARB_STATS_EN
  logic        freeze_d;
  logic [15:0] cnt [N_REQ];

  // saturating grant counters, cleared on freeze rising edge
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      freeze_d <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      freeze_d <= freeze;
      for (int i = 0; i < N_REQ; i++) begin
        if (freeze && !freeze_d) begin
          cnt[i] <= '0;
        end else if (grant_now && pick_idx == IW'(i)
                     && cnt[i] != 16'hFFFF) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter (N_REQ=4, AW=8, RD_LAT=2).
// ROM model: one register stage on rom_addr, q = addr[3:0].
module tb_sprite_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int LAT = 2;

  typedef struct {
    int         cyc;
    logic [3:0] v;
    logic [7:0] d;
  } exp_t;

  logic            vga_clk;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [3:0]      rom_q;
  logic [N-1:0]    rd_valid;
  logic [3:0]      rd_data;
  logic            freeze;
  logic            halted;
`ifdef SPRITE_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  sprite_rom_arbiter #(
    .N_REQ  (N),
    .AW     (AW),
    .RD_LAT (LAT)
  ) dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .freeze    (freeze),
    .halted    (halted)
`ifdef SPRITE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic [7:0] rom_stage = '0;
  always @(posedge vga_clk) rom_stage <= rom_addr;
  assign rom_q = rom_stage[3:0];

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int   errs = 0;
  int   checks = 0;
  bit   mon_en = 1'b1;
  exp_t gq[$];
  exp_t rq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic exp_g(input int c, input logic [3:0] v,
                       input logic [7:0] a);
    gq.push_back('{c, v, a});
  endtask

  task automatic exp_r(input int c, input logic [3:0] v,
                       input logic [3:0] d);
    rq.push_back('{c, v, {4'h0, d}});
  endtask

  exp_t ge;
  exp_t re;
  always @(negedge vga_clk) begin
    if (mon_en && gnt != '0) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", 32'(gnt), 32'd0);
      end else begin
        ge = gq.pop_front();
        chk("gnt_cycle", cyc, ge.cyc);
        chk("gnt_vec", 32'(gnt), 32'(ge.v));
        chk("rom_addr", 32'(rom_addr), 32'(ge.d));
      end
    end
    if (mon_en && rd_valid != '0) begin
      if (rq.size() == 0) begin
        chk("rd_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        re = rq.pop_front();
        chk("rd_cycle", cyc, re.cyc);
        chk("rd_valid", 32'(rd_valid), 32'(re.v));
        chk("rd_data", 32'(rd_data), 32'(re.d));
      end
    end
  end

  initial begin
    int c;
    reset_n  = 1'b0;
    req      = '0;
    freeze   = 1'b0;
    req_addr = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    reset_n = 1'b1;
    step();
    step();

    // all four held: rotating grants, one per cycle
    c = cyc;
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      exp_g(c + 1 + i, 4'(1 << (i % 4)), 8'(8'h10 + (i % 4)));
      exp_r(c + 3 + i, 4'(1 << (i % 4)), 4'(i % 4));
    end
    repeat (5) step();
    req = '0;
    repeat (4) step();

    // single requester 2 at 0x3C
    req_addr[23:16] = 8'h3C;
    c = cyc;
    req = 4'b0100;
    exp_g(c + 1, 4'b0100, 8'h3C);
    exp_r(c + 3, 4'b0100, 4'hC);
    step();
    req = '0;
    repeat (4) step();

    // freeze with two reads in flight
    c = cyc;
    req = 4'hF;
    exp_g(c + 1, 4'b1000, 8'h13);
    exp_g(c + 2, 4'b0001, 8'h10);
    exp_r(c + 3, 4'b1000, 4'h3);
    exp_r(c + 4, 4'b0001, 4'h0);
    step();
    step();
    freeze = 1'b1;
    step();
    chk("drain_halted_a", 32'(halted), 32'd0);
    step();
    chk("drain_halted_b", 32'(halted), 32'd0);
    step();
    chk("drain_halted_c", 32'(halted), 32'd1);
    req = '0;
    step();
    freeze = 1'b0;
    step();
    chk("unfreeze_halted", 32'(halted), 32'd0);
    repeat (3) step();

    // freeze and request rise together
    freeze = 1'b1;
    req = 4'b0001;
    step();
    chk("idle_freeze_halted", 32'(halted), 32'd1);
    step();
    step();
    c = cyc;
    freeze = 1'b0;
    exp_g(c + 1, 4'b0001, 8'h10);
    exp_r(c + 3, 4'b0001, 4'h0);
    step();
    chk("resume_halted", 32'(halted), 32'd0);
    req = '0;
    repeat (4) step();

    // reset with two reads in flight
    req_addr[23:16] = 8'h3C;
    req_addr[15:8]  = 8'h15;
    c = cyc;
    req = 4'hF;
    exp_g(c + 1, 4'b0010, 8'h15);
    exp_g(c + 2, 4'b0100, 8'h3C);
    step();
    step();
    reset_n = 1'b0;
    req = '0;
    step();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    end
    c = cyc;
    req = 4'hF;
    exp_g(c + 1, 4'b0001, 8'h10);
    exp_r(c + 3, 4'b0001, 4'h0);
    step();
    req = '0;
    repeat (4) step();

    chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
    chk("rd_queue_empty", 32'(rq.size()), 32'd0);

`ifdef SPRITE_ARB_STATS_EN
    mon_en = 1'b0;
    req = 4'b0010;
    repeat (70000) step();
    req = '0;
    repeat (4) step();
    chk("cnt_saturate", 32'(grant_cnt[31:16]), 32'h0000FFFF);
    freeze = 1'b1;
    step();
    chk("cnt_freeze_clear", 32'(grant_cnt[31:16]), 32'd0);
    freeze = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
